// File: rtl/ysyx_2022040010_shift_pipe_if.sv
// Request/response bundle for the pipelined shifter: operand channel in, result channel out.
// The master side is the EXU producer/consumer; the slave side is the shifter itself.
interface ysyx_2022040010_shift_pipe_if #(
  parameter int XLEN = 64
);
  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] in_src;
  logic [XLEN-1:0] in_amt;
  logic [2:0]      in_op;
  logic            in_word;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_data;

  modport master (
    output in_valid, in_src, in_amt, in_op, in_word, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_src, in_amt, in_op, in_word, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/ysyx_2022040010_shift_pipe.sv
// Pipelined log barrel shifter (SLL/SRL/SRA plus RV64 word forms) with valid/ready and flush.
// Define YSYX_2022040010_SHIFT_ROT_EN to add ROL/ROR; otherwise ops 100/101 complete as NOP.
module ysyx_2022040010_shift_pipe #(
  parameter int XLEN   = 64,
  parameter int STAGES = 2
) (
  input logic clk,
  input logic rst_n,
  input logic flush,
  ysyx_2022040010_shift_pipe_if.slave bus
);
  localparam int LG   = $clog2(XLEN);
  localparam int BASE = LG / STAGES;
  localparam int REM  = LG % STAGES;

  // Right shifts travel through the left-shift datapath bit-reversed; mask tracks SRA fill.
  typedef struct packed {
    logic [XLEN-1:0] data;
    logic [XLEN-1:0] mask;
    logic [LG-1:0]   amt;
    logic            zero;
    logic            rev;
    logic            sign;
    logic            word;
    logic            rot;
  } entry_t;

  function automatic logic [XLEN-1:0] bit_rev(input logic [XLEN-1:0] x);
    logic [XLEN-1:0] r;
    for (int i = 0; i < XLEN; i++) r[i] = x[XLEN-1-i];
    return r;
  endfunction

  function automatic logic [XLEN-1:0] sext32(input logic [XLEN-1:0] x);
    logic [XLEN-1:0] r;
    for (int i = 0; i < XLEN; i++) r[i] = (i < 32) ? x[i] : x[31];
    return r;
  endfunction

  function automatic logic [XLEN-1:0] zext32(input logic [XLEN-1:0] x);
    logic [XLEN-1:0] r;
    for (int i = 0; i < XLEN; i++) r[i] = (i < 32) ? x[i] : 1'b0;
    return r;
  endfunction

  // Two copies of the low word let a full-width rotate produce the 32-bit rotate in the low half.
  function automatic logic [XLEN-1:0] dup32(input logic [XLEN-1:0] x);
    logic [XLEN-1:0] r;
    for (int i = 0; i < XLEN; i++) r[i] = x[i % 32];
    return r;
  endfunction

  function automatic entry_t shift_group(input entry_t e, input int lo, input int cnt);
    entry_t r;
    r = e;
    for (int j = 0; j < LG; j++) begin
      if (j >= lo && j < lo + cnt && r.amt[j]) begin
`ifdef YSYX_2022040010_SHIFT_ROT_EN
        if (r.rot) r.data = (r.data << (1 << j)) | (r.data >> (XLEN - (1 << j)));
        else       r.data = r.data << (1 << j);
`else
        r.data = r.data << (1 << j);
`endif
        r.mask = r.mask << (1 << j);
      end
    end
    return r;
  endfunction

  function automatic logic [XLEN-1:0] finalize(input entry_t e);
    logic [XLEN-1:0] r;
    r = e.rev ? bit_rev(e.data) : e.data;
    if (e.sign) r = r | ~bit_rev(e.mask);
    if (e.word) r = sext32(r);
    if (e.zero) r = '0;
    return r;
  endfunction

  logic            word_mode;
  logic [XLEN-1:0] operand;
  entry_t          in_entry;
  entry_t          st [STAGES];
  logic [STAGES-1:0] valid;
  logic [STAGES-1:0] adv;
  logic [STAGES-1:0] load;
  logic            unused_ok;

  assign word_mode = (XLEN == 64) && bus.in_word;

  always_comb begin
    in_entry      = '0;
    in_entry.mask = '1;
    in_entry.word = word_mode;
    in_entry.amt  = word_mode ? LG'(bus.in_amt[4:0]) : bus.in_amt[LG-1:0];
    operand       = bus.in_src;
    case (bus.in_op)
      3'b001: operand = word_mode ? zext32(bus.in_src) : bus.in_src;
      3'b010: begin
        in_entry.rev = 1'b1;
        operand      = word_mode ? zext32(bus.in_src) : bus.in_src;
      end
      3'b011: begin
        in_entry.rev  = 1'b1;
        in_entry.sign = word_mode ? bus.in_src[31] : bus.in_src[XLEN-1];
        operand       = word_mode ? sext32(bus.in_src) : bus.in_src;
      end
`ifdef YSYX_2022040010_SHIFT_ROT_EN
      3'b100: begin
        in_entry.rot = 1'b1;
        operand      = word_mode ? dup32(bus.in_src) : bus.in_src;
      end
      3'b101: begin
        in_entry.rot = 1'b1;
        in_entry.rev = 1'b1;
        operand      = word_mode ? dup32(bus.in_src) : bus.in_src;
      end
`endif
      default: in_entry.zero = 1'b1;
    endcase
    in_entry.data = in_entry.rev ? bit_rev(operand) : operand;
  end

  for (genvar i = 0; i < STAGES; i++) begin : g_stage
    localparam int LO  = i * BASE + ((i < REM) ? i : REM);
    localparam int CNT = BASE + ((i < REM) ? 1 : 0);
    entry_t prev;
    entry_t nxt;
    entry_t e_q;
    logic   v_q;

    if (i == 0) begin : g_head
      assign prev    = in_entry;
      assign load[i] = bus.in_valid && bus.in_ready;
    end else begin : g_body
      assign prev    = st[i-1];
      assign load[i] = adv[i-1];
    end

    if (i == STAGES - 1) begin : g_tail
      assign adv[i] = valid[i] && bus.out_ready;
    end else begin : g_mid
      assign adv[i] = valid[i] && (!valid[i+1] || adv[i+1]);
    end

    // The last stage also merges fill and word sign-extension so out_data comes straight from a register.
    always_comb begin
      nxt = shift_group(prev, LO, CNT);
      if (i == STAGES - 1) nxt.data = finalize(nxt);
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v_q <= 1'b0;
        e_q <= '0;
      end else begin
        if (flush)        v_q <= 1'b0;
        else if (load[i]) v_q <= 1'b1;
        else if (adv[i])  v_q <= 1'b0;
        if (load[i] && !flush) e_q <= nxt;
      end
    end

    assign valid[i] = v_q;
    assign st[i]    = e_q;
  end

  assign bus.in_ready  = !valid[0] || adv[0];
  assign bus.out_valid = valid[STAGES-1];
  assign bus.out_data  = st[STAGES-1].data;
  assign unused_ok     = ^{bus.in_amt, st[STAGES-1]};
endmodule

// File: tb/tb_ysyx_2022040010_shift_pipe.sv
// Self-checking bench for ysyx_2022040010_shift_pipe (XLEN=64, STAGES=2).
// Expected results come from a plain-arithmetic model of the shift rules and a FIFO scoreboard.
module tb_ysyx_2022040010_shift_pipe;
  localparam int XLEN   = 64;
  localparam int STAGES = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;

  ysyx_2022040010_shift_pipe_if #(.XLEN(XLEN)) bus();

  ysyx_2022040010_shift_pipe #(.XLEN(XLEN), .STAGES(STAGES)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int          tests_run    = 0;
  int          tests_failed = 0;
  logic        s_ready, s_valid, s_acc, s_fire;
  logic [63:0] s_data;
  logic [63:0] exp_q[$];

  function automatic logic [63:0] model(input logic [2:0] op, input logic word,
                                        input logic [63:0] src, input logic [63:0] amt);
    logic [31:0] a, r32;
    logic [63:0] r;
    int n;
    if (word) begin
      a = src[31:0];
      n = int'(amt[4:0]);
      case (op)
        3'd1: r32 = a << n;
        3'd2: r32 = a >> n;
        3'd3: r32 = $signed(a) >>> n;
`ifdef YSYX_2022040010_SHIFT_ROT_EN
        3'd4: r32 = (a << n) | (a >> (32 - n));
        3'd5: r32 = (a >> n) | (a << (32 - n));
`endif
        default: r32 = 32'd0;
      endcase
      return {{32{r32[31]}}, r32};
    end
    n = int'(amt[5:0]);
    case (op)
      3'd1: r = src << n;
      3'd2: r = src >> n;
      3'd3: r = $signed(src) >>> n;
`ifdef YSYX_2022040010_SHIFT_ROT_EN
      3'd4: r = (src << n) | (src >> (64 - n));
      3'd5: r = (src >> n) | (src << (64 - n));
`endif
      default: r = 64'd0;
    endcase
    return r;
  endfunction

  task automatic drive(input logic v, input logic [2:0] op, input logic w,
                       input logic [63:0] src, input logic [63:0] amt);
    bus.in_valid = v;
    bus.in_op    = op;
    bus.in_word  = w;
    bus.in_src   = src;
    bus.in_amt   = amt;
  endtask

  // Sample on the falling edge, then step past the next rising edge.
  task automatic tick();
    @(negedge clk);
    s_ready = bus.in_ready;
    s_valid = bus.out_valid;
    s_data  = bus.out_data;
    s_acc   = bus.in_valid && s_ready && !flush;
    s_fire  = s_valid && bus.out_ready && !flush;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    drive(1'b0, 3'd0, 1'b0, 64'd0, 64'd0);
    bus.out_ready = 1'b1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    tests_run++;
    if (bus.out_valid !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_out_valid: got %b, expected 0", bus.out_valid);
    end
    tests_run++;
    if (bus.out_data !== 64'd0) begin
      tests_failed++;
      $display("[TB] FAIL reset_out_data: got %h, expected 0", bus.out_data);
    end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    tick();
    tests_run++;
    if (s_ready !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL reset_in_ready: got %b, expected 1", s_ready);
    end
  endtask

  task automatic test_directed();
    logic [2:0]  ops [7];
    logic        wds [7];
    logic [63:0] srcs[7];
    logic [63:0] amts[7];
    logic [63:0] exps[7];
    int lat;
    ops[0] = 3'd1; wds[0] = 0; srcs[0] = 64'h1;                amts[0] = 63;    exps[0] = 64'h8000000000000000;
    ops[1] = 3'd3; wds[1] = 0; srcs[1] = 64'h8000000000000000; amts[1] = 4;     exps[1] = 64'hF800000000000000;
    ops[2] = 3'd2; wds[2] = 0; srcs[2] = 64'h8000000000000000; amts[2] = 4;     exps[2] = 64'h0800000000000000;
    ops[3] = 3'd2; wds[3] = 1; srcs[3] = 64'hFFFFFFFF80000000; amts[3] = 0;     exps[3] = 64'hFFFFFFFF80000000;
    ops[4] = 3'd3; wds[4] = 1; srcs[4] = 64'h0000000080000000; amts[4] = 31;    exps[4] = 64'hFFFFFFFFFFFFFFFF;
    ops[5] = 3'd1; wds[5] = 1; srcs[5] = 64'h1;                amts[5] = 64'h3F; exps[5] = 64'hFFFFFFFF80000000;
`ifdef YSYX_2022040010_SHIFT_ROT_EN
    ops[6] = 3'd5; wds[6] = 0; srcs[6] = 64'h1;                amts[6] = 1;     exps[6] = 64'h8000000000000000;
`else
    ops[6] = 3'd5; wds[6] = 0; srcs[6] = 64'h1;                amts[6] = 1;     exps[6] = 64'h0;
`endif
    bus.out_ready = 1'b1;
    for (int k = 0; k < 7; k++) begin
      drive(1'b1, ops[k], wds[k], srcs[k], amts[k]);
      tick();
      drive(1'b0, 3'd0, 1'b0, 64'd0, 64'd0);
      lat = 0;
      for (int c = 1; c <= 8; c++) begin
        tick();
        if (s_valid) begin
          lat = c;
          break;
        end
      end
      tests_run++;
      if (lat !== STAGES) begin
        tests_failed++;
        $display("[TB] FAIL directed_latency[%0d]: got %0d cycles, expected %0d", k, lat, STAGES);
      end
      tests_run++;
      if (s_data !== exps[k]) begin
        tests_failed++;
        $display("[TB] FAIL directed_data[%0d]: got %h, expected %h", k, s_data, exps[k]);
      end
    end
  endtask

  task automatic test_random();
    logic [2:0]  op;
    logic        w, stalled;
    logic [63:0] src, amt, held;
    stalled = 1'b0;
    held    = 64'd0;
    exp_q.delete();
    for (int c = 0; c < 300; c++) begin
      op  = 3'($urandom_range(0, 7));
      w   = 1'($urandom_range(0, 1));
      src = {$urandom, $urandom};
      amt = {$urandom, $urandom};
      drive($urandom_range(0, 9) < 7, op, w, src, amt);
      bus.out_ready = $urandom_range(0, 9) < 6;
      tick();
      if (stalled) begin
        tests_run++;
        if ({s_valid, s_data} !== {1'b1, held}) begin
          tests_failed++;
          $display("[TB] FAIL random_hold: got %b/%h, expected 1/%h", s_valid, s_data, held);
        end
      end
      stalled = s_valid && !bus.out_ready;
      held    = s_data;
      if (s_acc) exp_q.push_back(model(op, w, src, amt));
      if (s_fire) begin
        tests_run++;
        if (exp_q.size() == 0) begin
          tests_failed++;
          $display("[TB] FAIL random_extra: got %h, expected no output", s_data);
        end else if (s_data !== exp_q[0]) begin
          tests_failed++;
          $display("[TB] FAIL random_data: got %h, expected %h", s_data, exp_q.pop_front());
        end else begin
          void'(exp_q.pop_front());
        end
      end
    end
    drive(1'b0, 3'd0, 1'b0, 64'd0, 64'd0);
    bus.out_ready = 1'b1;
    for (int c = 0; c < 20 && exp_q.size() > 0; c++) begin
      tick();
      if (s_fire) begin
        tests_run++;
        if (s_data !== exp_q[0]) begin
          tests_failed++;
          $display("[TB] FAIL random_drain_data: got %h, expected %h", s_data, exp_q[0]);
        end
        void'(exp_q.pop_front());
      end
    end
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("[TB] FAIL random_drain: got %0d results missing, expected 0", exp_q.size());
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0]  ops [4];
    logic        wds [4];
    logic [63:0] srcs[4];
    logic [63:0] amts[4];
    logic [63:0] held;
    int sent, got;
    ops[0] = 3'd2; ops[1] = 3'd3; ops[2] = 3'd1; ops[3] = 3'd3;
    wds[0] = 0;    wds[1] = 0;    wds[2] = 1;    wds[3] = 1;
    for (int k = 0; k < 4; k++) begin
      srcs[k] = {$urandom, $urandom} | 64'h8000000080000000;
      amts[k] = 64'($urandom_range(1, 63));
    end
    exp_q.delete();
    sent = 0;
    got  = 0;
    held = 64'd0;
    for (int c = 0; c < 30 && got < 4; c++) begin
      if (sent < 4) drive(1'b1, ops[sent], wds[sent], srcs[sent], amts[sent]);
      else          drive(1'b0, 3'd0, 1'b0, 64'd0, 64'd0);
      bus.out_ready = (c >= 5);
      tick();
      if (c == 2) begin
        tests_run++;
        if ({s_ready, s_valid} !== 2'b01) begin
          tests_failed++;
          $display("[TB] FAIL b2b_full: got ready/valid %b%b, expected 01", s_ready, s_valid);
        end
        held = s_data;
      end
      if (c == 3 || c == 4) begin
        tests_run++;
        if ({s_valid, s_data} !== {1'b1, held}) begin
          tests_failed++;
          $display("[TB] FAIL b2b_hold: got %b/%h, expected 1/%h", s_valid, s_data, held);
        end
      end
      if (s_acc) begin
        exp_q.push_back(model(ops[sent], wds[sent], srcs[sent], amts[sent]));
        sent++;
      end
      if (s_fire) begin
        tests_run++;
        if (exp_q.size() == 0 || s_data !== exp_q[0]) begin
          tests_failed++;
          $display("[TB] FAIL b2b_order[%0d]: got %h, expected %h", got, s_data,
                   (exp_q.size() == 0) ? 64'd0 : exp_q[0]);
        end
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        got++;
      end
    end
    tests_run++;
    if (got != 4) begin
      tests_failed++;
      $display("[TB] FAIL b2b_count: got %0d results, expected 4", got);
    end
    drive(1'b0, 3'd0, 1'b0, 64'd0, 64'd0);
    for (int c = 0; c < 3; c++) begin
      tick();
      tests_run++;
      if (s_valid !== 1'b0) begin
        tests_failed++;
        $display("[TB] FAIL b2b_no_dup: got out_valid %b, expected 0", s_valid);
      end
    end
  endtask

  task automatic test_flush();
    logic [63:0] src;
    int lat;
    bus.out_ready = 1'b1;
    drive(1'b1, 3'd1, 1'b0, 64'h11, 64'd4);
    tick();
    drive(1'b1, 3'd2, 1'b0, 64'h22, 64'd1);
    tick();
    drive(1'b1, 3'd3, 1'b0, 64'h33, 64'd2);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    drive(1'b0, 3'd0, 1'b0, 64'd0, 64'd0);
    for (int c = 0; c < 4; c++) begin
      tick();
      tests_run++;
      if (s_valid !== 1'b0) begin
        tests_failed++;
        $display("[TB] FAIL flush_quiet[%0d]: got out_valid %b, expected 0", c, s_valid);
      end
    end
    src = {$urandom, $urandom};
    drive(1'b1, 3'd3, 1'b0, src, 64'd7);
    tick();
    drive(1'b0, 3'd0, 1'b0, 64'd0, 64'd0);
    lat = 0;
    for (int c = 1; c <= 8; c++) begin
      tick();
      if (s_valid) begin
        lat = c;
        break;
      end
    end
    tests_run++;
    if (lat !== STAGES) begin
      tests_failed++;
      $display("[TB] FAIL flush_next_latency: got %0d cycles, expected %0d", lat, STAGES);
    end
    tests_run++;
    if (s_data !== model(3'd3, 1'b0, src, 64'd7)) begin
      tests_failed++;
      $display("[TB] FAIL flush_next_data: got %h, expected %h", s_data, model(3'd3, 1'b0, src, 64'd7));
    end
  endtask

  task automatic test_reset_mid();
    bus.out_ready = 1'b0;
    drive(1'b1, 3'd1, 1'b0, 64'h1234, 64'd0);
    tick();
    tick();
    drive(1'b0, 3'd0, 1'b0, 64'd0, 64'd0);
    tick();
    tests_run++;
    if ({s_valid, s_data} !== {1'b1, 64'h1234}) begin
      tests_failed++;
      $display("[TB] FAIL reset_mid_prefill: got %b/%h, expected 1/%h", s_valid, s_data, 64'h1234);
    end
    #2;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if ({bus.out_valid, bus.out_data} !== {1'b0, 64'd0}) begin
      tests_failed++;
      $display("[TB] FAIL reset_mid_async: got %b/%h, expected 0/0", bus.out_valid, bus.out_data);
    end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      tests_run++;
      if ({s_ready, s_valid} !== 2'b10) begin
        tests_failed++;
        $display("[TB] FAIL reset_mid_quiet[%0d]: got ready/valid %b%b, expected 10", c, s_ready, s_valid);
      end
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bus.out_ready = 1'b1;
    drive(1'b0, 3'd0, 1'b0, 64'd0, 64'd0);
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
